// File: rtl/mdu_ctrl_pkg.sv
// Shared definitions for the multiply/divide unit controller:
// opcode layout, FSM state encoding and opcode decode helpers.
package mdu_ctrl_pkg;

  localparam int unsigned MDOP_W     = 4;
  localparam int unsigned MDOP_MULT  = 0;
  localparam int unsigned MDOP_MULTU = 1;
  localparam int unsigned MDOP_DIV   = 2;
  localparam int unsigned MDOP_DIVU  = 3;

  typedef enum logic [2:0] {
    ST_IDLE = 3'd0,
    ST_MUL1 = 3'd1,
    ST_MUL2 = 3'd2,
    ST_DIV  = 3'd3,
    ST_DONE = 3'd4
  } mdu_state_e;

  function automatic logic op_is_mul(input logic [MDOP_W-1:0] op);
    return op[MDOP_MULT] | op[MDOP_MULTU];
  endfunction

  // Multiply bits win if a malformed opcode sets both kinds.
  function automatic logic op_is_div(input logic [MDOP_W-1:0] op);
    return (op[MDOP_DIV] | op[MDOP_DIVU]) & ~op_is_mul(op);
  endfunction

endpackage

// File: rtl/mdu_ctrl.sv
// MDU sequencing controller: steers the 2-stage multiplier and the iterative
// divider, raises EX stalls and commits results to HI/LO.
module mdu_ctrl
  import mdu_ctrl_pkg::*;
#(
  parameter int unsigned DIV_CYCLES = 32
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ex_valid_i,
  input  logic [MDOP_W-1:0] ex_mduop_i,
  input  logic              ex_rdhilo_i,
  input  logic              stall_i,
  input  logic              flush_i,
  output logic              mdus1_en_o,
  output logic              div_start_o,
  output logic              div_step_o,
  output logic              div_cancel_o,
  output logic [5:0]        div_cnt_o,
  output logic              hilo_we_o,
  output logic              stall_req_o,
  output logic              busy_o
);

  localparam logic [5:0] CNT_LAST = 6'(DIV_CYCLES - 1);

  mdu_state_e state_q, state_d;
  logic [5:0] cnt_q, cnt_d;

  logic op_nz_s, accept_s, acc_mul_s, acc_div_s, hold_hilo_s;
  logic mdus1_en_s, div_start_s, div_step_s, div_cancel_s, hilo_we_s, stall_req_s;

  // Next-state, iteration counter and strobe generation.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    mdus1_en_s   = 1'b0;
    div_start_s  = 1'b0;
    div_step_s   = 1'b0;
    div_cancel_s = 1'b0;
    hilo_we_s    = 1'b0;

    op_nz_s   = ex_mduop_i != {MDOP_W{1'b0}};
    accept_s  = ex_valid_i & op_nz_s & ~stall_i & ~flush_i &
                ((state_q == ST_IDLE) | (state_q == ST_MUL2));
    acc_mul_s = accept_s & op_is_mul(ex_mduop_i);
    acc_div_s = accept_s & op_is_div(ex_mduop_i);

    case (state_q)
      ST_IDLE: begin
        state_d = ST_IDLE;
      end
      ST_MUL1: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else if (!stall_i) begin
          state_d = ST_MUL2;
        end else begin
          state_d = ST_MUL1;
        end
      end
      ST_MUL2: begin
        if (flush_i) begin
          state_d = ST_IDLE;
        end else begin
          hilo_we_s = 1'b1;
          state_d   = ST_IDLE;
        end
      end
      ST_DIV: begin
        if (flush_i) begin
          div_cancel_s = 1'b1;
          cnt_d        = 6'd0;
          state_d      = ST_IDLE;
        end else begin
          div_step_s = 1'b1;
          if (cnt_q == CNT_LAST) begin
            state_d = ST_DONE;
          end else begin
            cnt_d = cnt_q + 6'd1;
          end
        end
      end
      ST_DONE: begin
        if (flush_i) begin
          div_cancel_s = 1'b1;
          cnt_d        = 6'd0;
          state_d      = ST_IDLE;
        end else if (!stall_i) begin
          hilo_we_s = 1'b1;
          cnt_d     = 6'd0;
          state_d   = ST_IDLE;
        end else begin
          state_d = ST_DONE;
        end
      end
      default: begin
        cnt_d   = 6'd0;
        state_d = ST_IDLE;
      end
    endcase

    // A new operation overrides the IDLE/MUL2 fall-through chosen above.
    if (acc_mul_s) begin
      mdus1_en_s = 1'b1;
      state_d    = ST_MUL1;
    end else if (acc_div_s) begin
      div_start_s = 1'b1;
      cnt_d       = 6'd0;
      state_d     = ST_DIV;
    end else begin
      mdus1_en_s = 1'b0;
    end

    hold_hilo_s = (state_q == ST_MUL1) | (state_q == ST_DIV) | (state_q == ST_DONE);
    stall_req_s = acc_div_s | (state_q == ST_DIV) | (state_q == ST_DONE) |
                  (ex_valid_i & (ex_rdhilo_i | op_nz_s) & hold_hilo_s);
  end

  // State and iteration counter registers.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= ST_IDLE;
      cnt_q   <= 6'd0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Outputs are forced low for the whole reset window, not just after the edge.
  assign mdus1_en_o   = mdus1_en_s   & rst_n;
  assign div_start_o  = div_start_s  & rst_n;
  assign div_step_o   = div_step_s   & rst_n;
  assign div_cancel_o = div_cancel_s & rst_n;
  assign hilo_we_o    = hilo_we_s    & rst_n;
  assign stall_req_o  = stall_req_s  & rst_n;
  assign busy_o       = (state_q != ST_IDLE) & rst_n;
  assign div_cnt_o    = cnt_q & {6{rst_n}};

endmodule
